// File: rtl/mem_stage_hs_if.sv
// Handshake and memory-bus bundle for the memory-access pipeline stage.
// The master view belongs to the stage. The slave view belongs to its surroundings (EX, memory, WB).
interface mem_stage_hs_if #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 30
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   IR_in;
  logic [PC_W-1:0]    PC_in;
  logic [WIDTH-1:0]   Z_in;
  logic [WIDTH-1:0]   Addr;
  logic               is_ld;
  logic               is_st;
  logic [1:0]         size;
  logic               uns;
  logic               mem_req;
  logic               mem_we;
  logic [WIDTH-1:0]   mem_addr;
  logic [WIDTH/8-1:0] mem_be;
  logic [WIDTH-1:0]   mem_wdata;
  logic               mem_ack;
  logic [WIDTH-1:0]   mem_rdata;
  logic               out_valid;
  logic [WIDTH-1:0]   IR_out;
  logic [PC_W-1:0]    PC_out;
  logic [WIDTH-1:0]   Z_out;
  logic [1:0]         exc;

  modport master (
    input  in_valid, IR_in, PC_in, Z_in, Addr, is_ld, is_st, size, uns,
    input  mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output out_valid, IR_out, PC_out, Z_out, exc
  );

  modport slave (
    output in_valid, IR_in, PC_in, Z_in, Addr, is_ld, is_st, size, uns,
    output mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  out_valid, IR_out, PC_out, Z_out, exc
  );
endinterface

// File: rtl/mem_stage_hs.sv
// Pipeline memory-access stage with a valid/ready input and a req/ack data-memory port.
// Byte, half, word and dword (WIDTH=64 only) accesses use lane-shifted data and byte enables.
// Loads are realigned and then sign- or zero-extended. Non-memory instructions pass through in one cycle.
module mem_stage_hs #(
  parameter int WIDTH   = 32,
  parameter int PC_W    = 30,
  parameter int TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst,
  mem_stage_hs_if.master bus
);
  localparam int BYTES  = WIDTH / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ADDR_MASK = ~(WIDTH'(BYTES - 1));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Contiguous mask of 2^sz byte lanes starting at the addressed lane.
  function automatic logic [BYTES-1:0] byte_enables(input logic [1:0] sz,
                                                    input logic [LANE_W-1:0] lane);
    logic [BYTES-1:0] be;
    logic [7:0]       lo;
    logic [7:0]       hi;
    lo = 8'(lane);
    hi = lo + (8'd1 << sz);
    for (int i = 0; i < BYTES; i++) begin
      be[i] = (8'(i) >= lo) && (8'(i) < hi);
    end
    return be;
  endfunction

  // An access is rejected if it is wider than the datapath or not naturally aligned.
  function automatic logic access_bad(input logic [1:0] sz, input logic [2:0] low_addr);
    logic legal;
    logic misal;
    legal = ((32'd8 << sz) <= 32'(WIDTH));
    misal = |(low_addr & ((3'd1 << sz) - 3'd1));
    return !legal || misal;
  endfunction

  // Move the addressed lanes down to bit 0, then extend from the top bit of the access.
  function automatic logic [WIDTH-1:0] load_extend(input logic [WIDTH-1:0]  rdata,
                                                   input logic [1:0]        sz,
                                                   input logic [LANE_W-1:0] lane,
                                                   input logic              zext);
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] mask;
    logic             sign;
    int               nbits;
    shifted = rdata >> {lane, 3'b000};
    nbits   = 32'd8 << sz;
    if (nbits > WIDTH) begin
      nbits = WIDTH;
    end else begin
      nbits = nbits;
    end
    sign = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i < nbits);
      if (i == nbits - 1) begin
        sign = shifted[i] & ~zext;
      end else begin
        sign = sign;
      end
    end
    return (shifted & mask) | ({WIDTH{sign}} & ~mask);
  endfunction

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [LANE_W-1:0]   lane_r;
  logic [1:0]          size_r;
  logic                uns_r;
  logic                is_ld_r;
  logic                in_ready_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [WIDTH-1:0]    mem_addr_r;
  logic [BYTES-1:0]    mem_be_r;
  logic [WIDTH-1:0]    mem_wdata_r;
  logic                out_valid_r;
  logic [WIDTH-1:0]    ir_r;
  logic [PC_W-1:0]     pc_r;
  logic [WIDTH-1:0]    z_r;
  logic [1:0]          exc_r;

  logic                mem_op_s;
  logic                bad_s;
  logic [LANE_W-1:0]   lane_s;

  // Classify the instruction presented by EX. Load and store together is treated as pass-through.
  always_comb begin
    mem_op_s = bus.is_ld ^ bus.is_st;
    lane_s   = bus.Addr[LANE_W-1:0];
    bad_s    = access_bad(bus.size, bus.Addr[2:0]);
  end

  // Stage FSM: accept in IDLE/RESP, hold the memory request in ACCESS, pulse out_valid per instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      lane_r      <= '0;
      size_r      <= 2'd0;
      uns_r       <= 1'b0;
      is_ld_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_be_r    <= '0;
      mem_wdata_r <= '0;
      out_valid_r <= 1'b0;
      ir_r        <= '0;
      pc_r        <= '0;
      z_r         <= '0;
      exc_r       <= 2'd0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE, RESP: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b1;
          if (bus.in_valid) begin
            ir_r <= bus.IR_in;
            pc_r <= bus.PC_in;
            if (!mem_op_s) begin
              out_valid_r <= 1'b1;
              z_r         <= bus.Z_in;
              exc_r       <= 2'd0;
            end else if (bad_s) begin
              out_valid_r <= 1'b1;
              z_r         <= '0;
              exc_r       <= 2'd1;
            end else begin
              state_r     <= ACCESS;
              in_ready_r  <= 1'b0;
              mem_req_r   <= 1'b1;
              mem_we_r    <= bus.is_st;
              mem_addr_r  <= bus.Addr & ADDR_MASK;
              mem_be_r    <= byte_enables(bus.size, lane_s);
              mem_wdata_r <= bus.Z_in << {lane_s, 3'b000};
              z_r         <= bus.Z_in;
              exc_r       <= 2'd0;
              cnt_r       <= '0;
              is_ld_r     <= bus.is_ld;
              size_r      <= bus.size;
              uns_r       <= bus.uns;
              lane_r      <= lane_s;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            state_r     <= RESP;
            in_ready_r  <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= '0;
            out_valid_r <= 1'b1;
            exc_r       <= 2'd0;
            if (is_ld_r) begin
              z_r <= load_extend(bus.mem_rdata, size_r, lane_r, uns_r);
            end
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= RESP;
            in_ready_r  <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= '0;
            out_valid_r <= 1'b1;
            z_r         <= '0;
            exc_r       <= 2'd2;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b1;
          mem_req_r  <= 1'b0;
          mem_we_r   <= 1'b0;
          mem_be_r   <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.out_valid = out_valid_r;
  assign bus.IR_out    = ir_r;
  assign bus.PC_out    = pc_r;
  assign bus.Z_out     = z_r;
  assign bus.exc       = exc_r;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (WIDTH=32, TIMEOUT=16).
module tb_mem_stage_hs;
  localparam int WIDTH   = 32;
  localparam int PC_W    = 30;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_stage_hs_if #(.WIDTH(WIDTH), .PC_W(PC_W)) bus ();

  mem_stage_hs #(.WIDTH(WIDTH), .PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.IR_in     = '0;
    bus.PC_in     = '0;
    bus.Z_in      = '0;
    bus.Addr      = '0;
    bus.is_ld     = 1'b0;
    bus.is_st     = 1'b0;
    bus.size      = 2'd0;
    bus.uns       = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [29:0] pc, input logic [31:0] z,
                       input logic [31:0] addr, input logic ld, input logic st,
                       input logic [1:0] sz, input logic u);
    bus.IR_in    = ir;
    bus.PC_in    = pc;
    bus.Z_in     = z;
    bus.Addr     = addr;
    bus.is_ld    = ld;
    bus.is_st    = st;
    bus.size     = sz;
    bus.uns      = u;
    bus.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.mem_req, bus.mem_we, bus.mem_be, bus.out_valid, bus.exc} !== 10'b1_0_0_0000_0_00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {bus.in_ready, bus.mem_req, bus.mem_we, bus.mem_be, bus.out_valid, bus.exc}, 10'b1_0_0_0000_0_00);
    end
    checks++;
    if ({bus.IR_out, bus.PC_out, bus.Z_out, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got IR=%h PC=%h Z=%h addr=%h wdata=%h expected all zero",
               bus.IR_out, bus.PC_out, bus.Z_out, bus.mem_addr, bus.mem_wdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_store_word();
    drive(32'h0000_1111, 30'h41, 32'hDEAD_BEEF, 32'h0000_0104, 1'b0, 1'b1, 2'd2, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.mem_req, bus.in_ready, bus.mem_we, bus.mem_be, bus.out_valid} !== 8'b1_0_1_1111_0) begin
      errors++;
      $display("FAIL sw_ctrl: got %b expected %b",
               {bus.mem_req, bus.in_ready, bus.mem_we, bus.mem_be, bus.out_valid}, 8'b1_0_1_1111_0);
    end
    checks++;
    if (bus.mem_addr !== 32'h0000_0104 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_bus: got addr=%h wdata=%h expected 00000104/deadbeef", bus.mem_addr, bus.mem_wdata);
    end
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_hold: got req=%b wdata=%h ov=%b expected 1/deadbeef/0", bus.mem_req, bus.mem_wdata, bus.out_valid);
    end
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    checks++;
    if ({bus.mem_req, bus.out_valid, bus.in_ready, bus.exc} !== 5'b0_1_1_00 || bus.Z_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_resp: got req/ov/rdy/exc=%b Z=%h expected 01100/deadbeef",
               {bus.mem_req, bus.out_valid, bus.in_ready, bus.exc}, bus.Z_out);
    end
    checks++;
    if (bus.IR_out !== 32'h0000_1111 || bus.PC_out !== 30'h41) begin
      errors++;
      $display("FAIL sw_irpc: got IR=%h PC=%h expected 00001111/41", bus.IR_out, bus.PC_out);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_pulse: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_load_byte(input logic u, input logic [31:0] exp_z);
    drive(32'h0000_2220 | 32'(u), 30'h80, 32'h5555_5555, 32'h0000_0203, 1'b1, 1'b0, 2'd0, u);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b1_0_1000 || bus.mem_addr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL lb_bus(uns=%0d): got req/we/be=%b addr=%h expected 101000/00000200",
               u, {bus.mem_req, bus.mem_we, bus.mem_be}, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8000_0000;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Z_out !== exp_z || bus.exc !== 2'd0) begin
      errors++;
      $display("FAIL lb_data(uns=%0d): got ov=%b Z=%h exc=%0d expected 1/%h/0", u, bus.out_valid, bus.Z_out, bus.exc, exp_z);
    end
    step();
  endtask

  task automatic test_half_access();
    drive(32'h0000_3333, 30'h90, 32'h0000_ABCD, 32'h0000_0012, 1'b0, 1'b1, 2'd1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_be !== 4'b1100 || bus.mem_wdata[31:16] !== 16'hABCD || bus.mem_addr !== 32'h0000_0010) begin
      errors++;
      $display("FAIL sh_bus: got be=%b wdata=%h addr=%h expected 1100/abcd..../00000010", bus.mem_be, bus.mem_wdata, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Z_out !== 32'h0000_ABCD) begin
      errors++;
      $display("FAIL sh_resp: got ov=%b Z=%h expected 1/0000abcd", bus.out_valid, bus.Z_out);
    end
    step();
    drive(32'h0000_3334, 30'h91, 32'h0, 32'h0000_0022, 1'b1, 1'b0, 2'd1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_be !== 4'b1100) begin
      errors++;
      $display("FAIL lh_be: got %b expected 1100", bus.mem_be);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8001_1234;
    step();
    bus.mem_ack   = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Z_out !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL lh_data: got ov=%b Z=%h expected 1/ffff8001", bus.out_valid, bus.Z_out);
    end
    step();
  endtask

  task automatic test_misaligned();
    drive(32'h0000_4444, 30'hA0, 32'h1234_5678, 32'h0000_0101, 1'b1, 1'b0, 2'd2, 1'b0);
    step();
    checks++;
    if ({bus.mem_req, bus.out_valid, bus.in_ready, bus.exc} !== 5'b0_1_1_01 || bus.Z_out !== 32'h0) begin
      errors++;
      $display("FAIL mis_lw: got req/ov/rdy/exc=%b Z=%h expected 01101/00000000",
               {bus.mem_req, bus.out_valid, bus.in_ready, bus.exc}, bus.Z_out);
    end
    drive(32'h0000_4445, 30'hA1, 32'h0000_0077, 32'h0000_0100, 1'b1, 1'b0, 2'd3, 1'b0);
    step();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.exc !== 2'd1 || bus.IR_out !== 32'h0000_4445) begin
      errors++;
      $display("FAIL mis_dword: got req=%b ov=%b exc=%0d IR=%h expected 0/1/1/00004445",
               bus.mem_req, bus.out_valid, bus.exc, bus.IR_out);
    end
    drive(32'h0000_4446, 30'hA2, 32'h0000_0077, 32'h0000_0013, 1'b0, 1'b1, 2'd1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.exc !== 2'd1) begin
      errors++;
      $display("FAIL mis_sh: got req=%b ov=%b exc=%0d expected 0/1/1", bus.mem_req, bus.out_valid, bus.exc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] irs [3];
    logic [31:0] zs  [3];
    irs = '{32'h0000_A001, 32'h0000_A002, 32'h0000_A003};
    zs  = '{32'h0000_0001, 32'hFFFF_0002, 32'h0000_0003};
    for (int i = 0; i < 3; i++) begin
      drive(irs[i], 30'(i + 16), zs[i], 32'h0000_0101, i == 2, i == 2, 2'd2, 1'b0);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.Z_out !== zs[i] || bus.IR_out !== irs[i] || bus.exc !== 2'd0 || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL b2b_alu[%0d]: got ov=%b Z=%h IR=%h exc=%0d req=%b expected 1/%h/%h/0/0",
                 i, bus.out_valid, bus.Z_out, bus.IR_out, bus.exc, bus.mem_req, zs[i], irs[i]);
      end
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got out_valid=%b expected 0", bus.out_valid);
    end
    drive(32'h0000_B001, 30'h50, 32'h1111_2222, 32'h0000_0500, 1'b0, 1'b1, 2'd2, 1'b0);
    step();
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b1;
    step();
    bus.mem_ack  = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.Z_out !== 32'h1111_2222) begin
      errors++;
      $display("FAIL resp_store: got ov=%b rdy=%b Z=%h expected 1/1/11112222", bus.out_valid, bus.in_ready, bus.Z_out);
    end
    drive(32'h0000_B002, 30'h51, 32'h0000_0033, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Z_out !== 32'h0000_0033 || bus.IR_out !== 32'h0000_B002) begin
      errors++;
      $display("FAIL resp_accept: got ov=%b Z=%h IR=%h expected 1/00000033/0000b002", bus.out_valid, bus.Z_out, bus.IR_out);
    end
    step();
  endtask

  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    drive(32'h0000_C001, 30'h60, 32'h0, 32'h0000_0300, 1'b1, 1'b0, 2'd2, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_req === 1'b1) begin
        req_cycles++;
        step();
      end
    end
    checks++;
    if (req_cycles != TIMEOUT) begin
      errors++;
      $display("FAIL to_req_cycles: got %0d expected %0d", req_cycles, TIMEOUT);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.exc !== 2'd2 || bus.IR_out !== 32'h0000_C001) begin
      errors++;
      $display("FAIL to_resp: got ov=%b exc=%0d IR=%h expected 1/2/0000c001", bus.out_valid, bus.exc, bus.IR_out);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    bus.mem_ack   = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_late_ack: got ov=%b req=%b rdy=%b expected 0/0/1", bus.out_valid, bus.mem_req, bus.in_ready);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive(32'h0000_D001, 30'h70, 32'h0, 32'h0000_0400, 1'b1, 1'b0, 2'd2, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rm_req_before: got %b expected 1", bus.mem_req);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: got req=%b rdy=%b ov=%b expected 0/1/0", bus.mem_req, bus.in_ready, bus.out_valid);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rm_discard[%0d]: got ov=%b rdy=%b expected 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
    drive(32'h0000_D002, 30'h71, 32'h0, 32'h0000_0404, 1'b1, 1'b0, 2'd2, 1'b0);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0404) begin
      errors++;
      $display("FAIL rm_next_req: got req=%b addr=%h expected 1/00000404", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_ack   = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Z_out !== 32'h1234_5678 || bus.IR_out !== 32'h0000_D002 || bus.exc !== 2'd0) begin
      errors++;
      $display("FAIL rm_next_load: got ov=%b Z=%h IR=%h exc=%0d expected 1/12345678/0000d002/0",
               bus.out_valid, bus.Z_out, bus.IR_out, bus.exc);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_word();
    test_load_byte(1'b0, 32'hFFFF_FF80);
    test_load_byte(1'b1, 32'h0000_0080);
    test_half_access();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised successor of the pipeline memory-access stage.
- Accepts one instruction per handshake from EX and runs a byte/half/word load or store against a data memory with a req/ack handshake.
- Aligns and sign/zero-extends load data, and passes non-memory instructions through.
- Drives WB with IR/PC/result; stalls EX via in_ready while a memory access is outstanding; flags misaligned accesses and memory timeouts.

Parameters:
- WIDTH, 32, datapath and IR width in bits (multiple of 8, max 64)
- PC_W, 30, PC width (WIDTH-2 by codebase convention)
- TIMEOUT, 16, max cycles to wait for mem_ack before error (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept this cycle
- IR_in  in  WIDTH  instruction
- PC_in  in  PC_W  program counter
- Z_in  in  WIDTH  ALU result / store data
- Addr  in  WIDTH  effective address
- is_ld  in  1  load
- is_st  in  1  store (is_ld & is_st is illegal and treated as pass-through)
- size  in  2  0=byte, 1=half, 2=word(32b), 3=dword (legal only if WIDTH=64)
- uns  in  1  zero-extend load when 1
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  WIDTH  word-aligned address (low log2(WIDTH/8) bits zero)
- mem_be  out  WIDTH/8  byte enables
- mem_wdata  out  WIDTH  lane-shifted store data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  WIDTH  read data, valid with mem_ack
- out_valid  out  1  result valid to WB (one-cycle pulse per instruction)
- IR_out  out  WIDTH  registered IR
- PC_out  out  PC_W  registered PC
- Z_out  out  WIDTH  load data, or Z_in for non-loads
- exc  out  2  0=none, 1=misaligned, 2=timeout; valid with out_valid

Behaviour:
- Reset: FSM=IDLE; in_ready=1; mem_req=0; mem_we=0; mem_be=0; out_valid=0; IR_out, PC_out, Z_out, mem_addr, mem_wdata=0; exc=0; timeout counter=0.
- Accept: a transfer occurs when in_valid & in_ready at posedge clk. All inputs are captured at that edge.
- FSM states IDLE, ACCESS, RESP.
- IDLE, transfer accepted:
  - Non-memory instruction: next cycle out_valid=1, Z_out=Z_in, exc=0. Latency 1, so back-to-back non-memory ops give full throughput.
  - Illegal size (3 with WIDTH=32): handled as misaligned.
  - Misaligned access (half with Addr[0]!=0, word with Addr[1:0]!=0, dword with Addr[2:0]!=0): no mem_req; next cycle out_valid=1, exc=1, Z_out=0.
  - Legal access: go to ACCESS; mem_req=1; in_ready=0.
- ACCESS:
  - mem_req held high, and mem_addr/mem_we/mem_be/mem_wdata held stable, until mem_ack.
  - Counter increments each cycle without ack.
  - mem_ack seen: mem_req drops at that edge, rdata is captured, go to RESP.
  - Counter reaches TIMEOUT-1 without ack: mem_req drops, exc=2, go to RESP; a later stray mem_ack is ignored.
- RESP: out_valid=1 for one cycle, in_ready=1, return to IDLE. A memory op therefore takes at least 3 cycles accept-to-out_valid (ack in the first ACCESS cycle).
- mem_be is the contiguous mask of 2^size bytes starting at lane Addr[log2(WIDTH/8)-1:0].
- mem_wdata is Z_in's low 2^size bytes replicated/shifted into the selected lanes.
- Load data: the selected lanes are shifted to bit 0, then sign-extended from the top bit of the access (uns=0) or zero-extended (uns=1). A store returns Z_out=Z_in.
- in_ready is 1 in IDLE and RESP, 0 in ACCESS. A new instruction may be accepted in the RESP cycle; its out_valid follows the current one's by at least 1 cycle.
- rst asserted mid-access: immediate return to reset values; mem_req drops asynchronously; the in-flight instruction is discarded (no out_valid).
- IR/PC are always forwarded unchanged with their own instruction's out_valid.

Test Plan:
- Store word: WIDTH=32, is_st, size=2, Addr=0x104, Z_in=0xDEADBEEF, ack after 2 cycles -> mem_addr=0x104, mem_be=4'b1111, mem_wdata=0xDEADBEEF, req high 2 cycles, out_valid at cycle 4, exc=0.
- Byte load with sign: Addr=0x203, size=0, uns=0, mem_rdata=0x80_00_00_00 -> mem_be=4'b1000, Z_out=0xFFFFFF80. Repeat with uns=1 -> Z_out=0x00000080.
- Half store lane: Addr=0x12, size=1, Z_in=0x0000ABCD -> mem_be=4'b1100, mem_wdata[31:16]=0xABCD.
- Misaligned: load word Addr=0x101 -> no mem_req, out_valid next cycle with exc=1, Z_out=0. Then back-to-back ALU ops -> one out_valid per cycle, Z_out=Z_in.
- Timeout: TIMEOUT=16, load, mem_ack never asserted -> mem_req high exactly 16 cycles, out_valid with exc=2; a late mem_ack has no effect.
- Reset mid-access: assert rst during ACCESS -> mem_req=0 immediately, no out_valid, in_ready=1 after release; the next load completes normally.
